// File: rtl/reset_sequencer.sv
// reset_sequencer: qualifies PLL lock, then releases NUM_CH
// active-low resets one at a time after a hold period.
module reset_sequencer #(
  parameter int NUM_CH         = 4,
  parameter int HOLD_CYCLES    = 100,
  parameter int STAGGER_CYCLES = 16,
  parameter int LOCK_FILTER    = 8,
  parameter bit RELOCK_EN      = 1'b1,
  parameter int CNT_W          = 16
) (
  input  logic              clk_In,
  input  logic              rst_In,
  input  logic              clk_lock,
  input  logic              sw_rst_req,
  output logic [NUM_CH-1:0] rst_n_out,
  output logic              ready_out,
  output logic              lock_lost_out,
  output logic [7:0]        lock_lost_cnt
);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    HOLD,
    RELEASE,
    RUN
  } state_t;

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CNT_W-1:0] FILT_END =
    CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] HOLD_END =
    CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_END =
    CNT_W'(STAGGER_CYCLES - 1);
  // index of the channel whose successor is the last one
  localparam logic [IDX_W-1:0] IDX_PENULT =
    IDX_W'((NUM_CH > 1) ? NUM_CH - 2 : 0);

  logic              r_s1;
  logic              r_s2;
  state_t            r_state;
  state_t            w_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx;
  logic [NUM_CH-1:0] r_rst_n;
  logic [NUM_CH-1:0] w_rst_n;
  logic [NUM_CH-1:0] w_mask;
  logic              r_ready;
  logic              w_ready;
  logic              r_lost;
  logic              w_lost;
  logic [7:0]        r_lost_cnt;
  logic [7:0]        w_lost_cnt;
  logic              w_active;
  logic              w_loss;

  // two-flop synchroniser for the asynchronous lock input
  always_ff @(posedge clk_In) begin
    if (rst_In) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= clk_lock;
      r_s2 <= r_s1;
    end
  end

  // sequencer state and registered outputs
  always_ff @(posedge clk_In) begin
    if (rst_In) begin
      r_state    <= WAIT_LOCK;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_rst_n    <= '0;
      r_ready    <= 1'b0;
      r_lost     <= 1'b0;
      r_lost_cnt <= '0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_idx      <= w_idx;
      r_rst_n    <= w_rst_n;
      r_ready    <= w_ready;
      r_lost     <= w_lost;
      r_lost_cnt <= w_lost_cnt;
    end
  end

  // one-hot mask of the channel released next
  always_comb begin
    w_mask = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (k == int'(r_idx) + 1) begin
        w_mask[k] = 1'b1;
      end
    end
  end

  // next state: lock loss beats software request
  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_idx      = r_idx;
    w_rst_n    = r_rst_n;
    w_ready    = r_ready;
    w_lost     = r_lost;
    w_lost_cnt = r_lost_cnt;
    w_active   = (r_state != WAIT_LOCK);
    w_loss     = w_active && RELOCK_EN && !r_s2;
    if (w_loss) begin
      w_state = WAIT_LOCK;
      w_cnt   = '0;
      w_idx   = '0;
      w_rst_n = '0;
      w_ready = 1'b0;
      w_lost  = 1'b1;
      if (r_lost_cnt != 8'hFF) begin
        w_lost_cnt = r_lost_cnt + 8'd1;
      end
    end else if (w_active && sw_rst_req) begin
      w_state = HOLD;
      w_cnt   = '0;
      w_idx   = '0;
      w_rst_n = '0;
      w_ready = 1'b0;
    end else begin
      unique case (r_state)
        WAIT_LOCK: begin
          if (!r_s2) begin
            w_cnt = '0;
          end else if (r_cnt == FILT_END) begin
            w_state = HOLD;
            w_cnt   = '0;
          end else begin
            w_cnt = r_cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          if (r_cnt == HOLD_END) begin
            w_cnt      = '0;
            w_idx      = '0;
            w_rst_n[0] = 1'b1;
            if (NUM_CH == 1) begin
              w_state = RUN;
              w_ready = 1'b1;
            end else begin
              w_state = RELEASE;
            end
          end else begin
            w_cnt = r_cnt + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (r_cnt == STAG_END) begin
            w_cnt   = '0;
            w_idx   = r_idx + IDX_W'(1);
            w_rst_n = r_rst_n | w_mask;
            if (r_idx == IDX_PENULT) begin
              w_state = RUN;
              w_ready = 1'b1;
            end
          end else begin
            w_cnt = r_cnt + CNT_W'(1);
          end
        end
        RUN: begin
          w_rst_n = '1;
          w_ready = 1'b1;
        end
      endcase
    end
  end

  assign rst_n_out     = r_rst_n;
  assign ready_out     = r_ready;
  assign lock_lost_out = r_lost;
  assign lock_lost_cnt = r_lost_cnt;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: four configurations of the sequencer
// driven in parallel, checked against a timing model.
module tb_reset_sequencer;

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic lock = 1'b0;
  logic sw   = 1'b0;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ecount = 0;
  bit mon_en = 1'b0;

  logic [3:0] a_rst, b_rst, d_rst;
  logic [0:0] c_rst;
  logic a_rdy, b_rdy, c_rdy, d_rdy;
  logic a_lost, b_lost, c_lost, d_lost;
  logic [7:0] a_cnt, b_cnt, c_cnt, d_cnt;

  reset_sequencer u_a (
    .clk_In(clk), .rst_In(rst), .clk_lock(lock),
    .sw_rst_req(sw), .rst_n_out(a_rst),
    .ready_out(a_rdy), .lock_lost_out(a_lost),
    .lock_lost_cnt(a_cnt));

  reset_sequencer #(.RELOCK_EN(1'b0)) u_b (
    .clk_In(clk), .rst_In(rst), .clk_lock(lock),
    .sw_rst_req(sw), .rst_n_out(b_rst),
    .ready_out(b_rdy), .lock_lost_out(b_lost),
    .lock_lost_cnt(b_cnt));

  reset_sequencer #(
    .NUM_CH(1), .HOLD_CYCLES(5), .LOCK_FILTER(3)
  ) u_c (
    .clk_In(clk), .rst_In(rst), .clk_lock(lock),
    .sw_rst_req(sw), .rst_n_out(c_rst),
    .ready_out(c_rdy), .lock_lost_out(c_lost),
    .lock_lost_cnt(c_cnt));

  reset_sequencer #(
    .STAGGER_CYCLES(1), .HOLD_CYCLES(7), .LOCK_FILTER(2)
  ) u_d (
    .clk_In(clk), .rst_In(rst), .clk_lock(lock),
    .sw_rst_req(sw), .rst_n_out(d_rst),
    .ready_out(d_rdy), .lock_lost_out(d_lost),
    .lock_lost_cnt(d_cnt));

  logic [3:0] o_rst [4];
  logic       o_rdy [4];
  logic       o_lost[4];
  logic [7:0] o_cnt [4];

  assign o_rst[0] = a_rst;
  assign o_rst[1] = b_rst;
  assign o_rst[2] = {3'b000, c_rst};
  assign o_rst[3] = d_rst;
  assign o_rdy[0] = a_rdy;
  assign o_rdy[1] = b_rdy;
  assign o_rdy[2] = c_rdy;
  assign o_rdy[3] = d_rdy;
  assign o_lost[0] = a_lost;
  assign o_lost[1] = b_lost;
  assign o_lost[2] = c_lost;
  assign o_lost[3] = d_lost;
  assign o_cnt[0] = a_cnt;
  assign o_cnt[1] = b_cnt;
  assign o_cnt[2] = c_cnt;
  assign o_cnt[3] = d_cnt;

  localparam int P_NCH [4] = '{4, 4, 1, 4};
  localparam int P_HOLD[4] = '{100, 100, 5, 7};
  localparam int P_STAG[4] = '{16, 16, 16, 1};
  localparam int P_LF  [4] = '{8, 8, 3, 2};
  localparam int P_RE  [4] = '{1, 0, 1, 1};

  // model: lock seen two edges late, run length of
  // high samples, and the edge each sequence started
  logic m_s1 = 1'b0;
  logic m_s2 = 1'b0;
  int   run  = 0;
  bit   m_wait [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
  bit   m_lost [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
  int   m_start[4] = '{0, 0, 0, 0};
  int   m_cnt  [4] = '{0, 0, 0, 0};

  always @(posedge clk) begin
    ecount <= ecount + 1;
    if (rst) begin
      m_s1 <= 1'b0;
      m_s2 <= 1'b0;
      run  <= 0;
      for (int i = 0; i < 4; i++) begin
        m_wait[i]  <= 1'b1;
        m_lost[i]  <= 1'b0;
        m_cnt[i]   <= 0;
        m_start[i] <= 0;
      end
    end else begin
      m_s1 <= lock;
      m_s2 <= m_s1;
      run  <= m_s2 ? run + 1 : 0;
      for (int i = 0; i < 4; i++) begin
        if (m_wait[i]) begin
          if ((m_s2 ? run + 1 : 0) >= P_LF[i]) begin
            m_wait[i]  <= 1'b0;
            m_start[i] <= ecount + 1;
          end
        end else if (P_RE[i] != 0 && !m_s2) begin
          m_wait[i] <= 1'b1;
          m_lost[i] <= 1'b1;
          m_cnt[i]  <= (m_cnt[i] >= 255) ? 255
                                          : m_cnt[i] + 1;
        end else if (sw) begin
          m_start[i] <= ecount + 1;
        end
      end
    end
  end

  // channel k of a started sequence is free once
  // HOLD + k*STAGGER edges have passed
  always @(negedge clk) begin : mon
    logic [3:0] ev;
    logic       er;
    int         base;
    if (mon_en) begin
      for (int i = 0; i < 4; i++) begin
        base = m_start[i] + P_HOLD[i];
        ev   = '0;
        for (int k = 0; k < P_NCH[i]; k++) begin
          ev[k] = !m_wait[i] &&
                  ecount >= base + k * P_STAG[i];
        end
        er = !m_wait[i] && ecount >=
             base + (P_NCH[i] - 1) * P_STAG[i];
        checks++;
        if ({o_rst[i], o_rdy[i], o_lost[i], o_cnt[i]}
            !== {ev, er, m_lost[i], 8'(m_cnt[i])}) begin
          errors++;
          $display(
            "FAIL model dut%0d edge %0d: got rst_n=%b rdy=%b lost=%b cnt=%0d want rst_n=%b rdy=%b lost=%b cnt=%0d",
            i, ecount, o_rst[i], o_rdy[i], o_lost[i],
            o_cnt[i], ev, er, m_lost[i], m_cnt[i]);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    sw   = 1'b0;
    lock = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    lock = 1'b0;
    sw   = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      mon_en = 1'b1;
      checks++;
      if ({a_rst, a_rdy, a_lost, a_cnt, b_rst,
           c_rst, c_rdy, d_rst, d_rdy} !== 27'd0) begin
        errors++;
        $display("FAIL reset edge %0d: a=%b/%b/%b/%0d want 0",
                 ecount, a_rst, a_rdy, a_lost, a_cnt);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_release_timing();
    int t;
    int ra[4];
    int rd[4];
    int rc0;
    int rcr;
    int rar;
    ra  = '{-1, -1, -1, -1};
    rd  = '{-1, -1, -1, -1};
    rc0 = -1;
    rcr = -1;
    rar = -1;
    @(negedge clk);
    lock = 1'b1;
    t    = ecount + 1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (ra[k] < 0 && a_rst[k] === 1'b1) ra[k] = ecount;
        if (rd[k] < 0 && d_rst[k] === 1'b1) rd[k] = ecount;
      end
      if (rc0 < 0 && c_rst[0] === 1'b1) rc0 = ecount;
      if (rcr < 0 && c_rdy === 1'b1) rcr = ecount;
      if (rar < 0 && a_rdy === 1'b1) rar = ecount;
      if (rar >= 0 && rcr >= 0 && rd[3] >= 0) break;
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ra[k] != t + 109 + 16 * k) begin
        errors++;
        $display("FAIL release_a%0d: edge %0d want %0d",
                 k, ra[k], t + 109 + 16 * k);
      end
      checks++;
      if (rd[k] != t + 10 + k) begin
        errors++;
        $display("FAIL stagger1_d%0d: edge %0d want %0d",
                 k, rd[k], t + 10 + k);
      end
    end
    checks++;
    if (rar != t + 157) begin
      errors++;
      $display("FAIL ready_a: edge %0d want %0d",
               rar, t + 157);
    end
    checks++;
    if (rc0 != t + 9 || rcr != t + 9) begin
      errors++;
      $display("FAIL one_ch: ch0 %0d rdy %0d want %0d",
               rc0, rcr, t + 9);
    end
  endtask

  task automatic test_glitch();
    int t;
    do_reset();
    @(negedge clk);
    lock = 1'b1;
    repeat (5) @(negedge clk);
    lock = 1'b0;
    @(negedge clk);
    lock = 1'b1;
    t    = ecount + 1;
    for (int n = 0; n < 200; n++) begin
      if (a_rst[0] === 1'b1) break;
      @(negedge clk);
    end
    checks++;
    if (a_rst[0] !== 1'b1 || ecount != t + 109) begin
      errors++;
      $display("FAIL glitch_ch0: edge %0d bit %b want %0d",
               ecount, a_rst[0], t + 109);
    end
    for (int n = 0; n < 200; n++) begin
      if (a_rdy === 1'b1) break;
      @(negedge clk);
    end
  endtask

  task automatic test_lock_loss();
    int n0;
    checks++;
    if (a_rdy !== 1'b1 || a_rst !== 4'hF) begin
      errors++;
      $display("FAIL loss_pre: rdy %b rst %b want 1 1111",
               a_rdy, a_rst);
    end
    lock = 1'b0;
    n0   = ecount;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (a_rst !== 4'hF) begin
        errors++;
        $display("FAIL loss_early edge %0d: %b want 1111",
                 ecount, a_rst);
      end
    end
    @(negedge clk);
    lock = 1'b1;
    checks++;
    if ({a_rst, a_rdy, a_lost, a_cnt} !==
        {4'h0, 1'b0, 1'b1, 8'd1}) begin
      errors++;
      $display("FAIL loss_a: %b/%b/%b/%0d want 0000/0/1/1",
               a_rst, a_rdy, a_lost, a_cnt);
    end
    checks++;
    if ({b_rst, b_rdy, b_lost, b_cnt} !==
        {4'hF, 1'b1, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL norelock_b: %b/%b/%b/%0d want 1111/1/0/0",
               b_rst, b_rdy, b_lost, b_cnt);
    end
    for (int n = 0; n < 200; n++) begin
      if (a_rst[0] === 1'b1) break;
      @(negedge clk);
    end
    checks++;
    if (a_rst[0] !== 1'b1 || ecount != n0 + 4 + 109) begin
      errors++;
      $display("FAIL relock_ch0: edge %0d want %0d",
               ecount, n0 + 113);
    end
  endtask

  task automatic test_loss_saturation();
    for (int n = 0; n < 300; n++) begin
      lock = 1'b1;
      repeat (12) @(negedge clk);
      lock = 1'b0;
      @(negedge clk);
    end
    lock = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (a_cnt !== 8'd255 || a_lost !== 1'b1) begin
      errors++;
      $display("FAIL saturate_a: cnt %0d lost %b want 255 1",
               a_cnt, a_lost);
    end
    checks++;
    if (b_cnt !== 8'd0 || b_lost !== 1'b0) begin
      errors++;
      $display("FAIL saturate_b: cnt %0d lost %b want 0 0",
               b_cnt, b_lost);
    end
  endtask

  task automatic test_sw_req();
    int t;
    int r0;
    int l0;
    int n0;
    do_reset();
    @(negedge clk);
    lock = 1'b1;
    t    = ecount + 1;
    while (ecount < t + 145) @(negedge clk);
    checks++;
    if (a_rst !== 4'b0111 || a_rdy !== 1'b0) begin
      errors++;
      $display("FAIL sw_pre: %b rdy %b want 0111 0",
               a_rst, a_rdy);
    end
    sw = 1'b1;
    @(negedge clk);
    sw = 1'b0;
    checks++;
    if (a_rst !== 4'h0 || a_rdy !== 1'b0) begin
      errors++;
      $display("FAIL sw_clear: %b rdy %b want 0000 0",
               a_rst, a_rdy);
    end
    r0 = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (r0 < 0 && a_rst[0] === 1'b1) r0 = ecount;
      if (a_rdy === 1'b1) break;
    end
    checks++;
    if (r0 != t + 246 || a_rdy !== 1'b1 ||
        ecount != t + 294) begin
      errors++;
      $display("FAIL sw_rerelease: ch0 %0d ch3 %0d want %0d %0d",
               r0, ecount, t + 246, t + 294);
    end
    sw = 1'b1;
    repeat (50) @(negedge clk);
    checks++;
    if (a_rst !== 4'h0 || a_rdy !== 1'b0) begin
      errors++;
      $display("FAIL sw_held: %b rdy %b want 0000 0",
               a_rst, a_rdy);
    end
    l0 = ecount;
    sw = 1'b0;
    for (int n = 0; n < 150; n++) begin
      if (a_rst[0] === 1'b1) break;
      @(negedge clk);
    end
    checks++;
    if (a_rst[0] !== 1'b1 || ecount != l0 + 100) begin
      errors++;
      $display("FAIL sw_held_release: edge %0d want %0d",
               ecount, l0 + 100);
    end
    for (int n = 0; n < 100; n++) begin
      if (a_rdy === 1'b1) break;
      @(negedge clk);
    end
    lock = 1'b0;
    n0   = ecount;
    repeat (2) @(negedge clk);
    sw = 1'b1;
    @(negedge clk);
    sw   = 1'b0;
    lock = 1'b1;
    checks++;
    if (ecount != n0 + 3 || a_cnt !== 8'd1 ||
        a_rst !== 4'h0 || a_lost !== 1'b1) begin
      errors++;
      $display("FAIL loss_vs_sw: cnt %0d rst %b lost %b want 1 0000 1",
               a_cnt, a_rst, a_lost);
    end
    for (int n = 0; n < 300; n++) begin
      if (a_rdy === 1'b1) break;
      @(negedge clk);
    end
  endtask

  task automatic test_mid_reset();
    sw = 1'b1;
    @(negedge clk);
    sw = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (a_rst[1] === 1'b1) break;
      @(negedge clk);
    end
    checks++;
    if (a_rst !== 4'b0011 || a_rdy !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre: %b rdy %b want 0011 0",
               a_rst, a_rdy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({a_rst, a_rdy, a_lost, a_cnt, c_rst,
         c_rdy, d_rst, d_rdy} !== 22'd0) begin
      errors++;
      $display("FAIL mid_reset: a=%b/%b/%b/%0d c=%b d=%b want 0",
               a_rst, a_rdy, a_lost, a_cnt, c_rst, d_rst);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 999) == 0);
      sw  = ($urandom_range(0, 299) == 0);
      if (lock) lock = ($urandom_range(0, 199) != 0);
      else      lock = ($urandom_range(0, 4) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    sw  = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: edge %0d", ecount);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_release_timing();
    test_glitch();
    test_lock_loss();
    test_loss_saturation();
    test_sw_req();
    test_mid_reset();
    test_random();
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
